// File: rtl/al_accel_outpack_if.sv
// rtl/al_accel_outpack_if.sv - sample input and packed-word output handshakes for al_accel_outpack
interface al_accel_outpack_if;
    logic        in_vld;
    logic [31:0] in_data;
    logic        in_rdy;
    logic [31:0] pack_do;
    logic [3:0]  pack_be;
    logic        pack_vld;
    logic        pack_rdy;

    modport master (
        output in_vld, in_data, pack_rdy,
        input  in_rdy, pack_do, pack_be, pack_vld
    );

    modport slave (
        input  in_vld, in_data, pack_rdy,
        output in_rdy, pack_do, pack_be, pack_vld
    );
endinterface

// File: rtl/al_accel_outpack.sv
// rtl/al_accel_outpack.sv - zero-point add, activation clamp and 4-lane int8 word packer
module al_accel_outpack (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    al_accel_outpack_if.slave    bus,
    input  logic [31:0]          out_offset,
    input  logic [7:0]           act_min,
    input  logic [7:0]           act_max,
    input  logic                 flush,
    output logic [15:0]          word_cnt
);

    logic [1:0]         lane_idx;
    logic [23:0]        part;
    logic               flush_pend;
    logic signed [32:0] sum;
    logic signed [32:0] lo;
    logic signed [32:0] hi;
    logic signed [32:0] clamped;
    logic [7:0]         b;
    logic [3:0]         be_part;
    logic               ofree;
    logic               acc;

    // 33-bit add cannot wrap; clamp to the upper bound last so an inverted range yields act_max
    always_comb begin
        sum     = {bus.in_data[31], bus.in_data} + {out_offset[31], out_offset};
        lo      = {{25{act_min[7]}}, act_min};
        hi      = {{25{act_max[7]}}, act_max};
        clamped = (sum < lo) ? lo : sum;
        clamped = (clamped > hi) ? hi : clamped;
        b       = clamped[7:0];
    end

    always_comb begin
        case (lane_idx)
            2'd1:    be_part = 4'b0001;
            2'd2:    be_part = 4'b0011;
            2'd3:    be_part = 4'b0111;
            default: be_part = 4'b0000;
        endcase
    end

    assign ofree      = !bus.pack_vld || bus.pack_rdy;
    assign bus.in_rdy = !flush_pend && (lane_idx != 2'd3 || ofree);
    assign acc        = bus.in_vld && bus.in_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_idx     <= 2'd0;
            part         <= 24'd0;
            flush_pend   <= 1'b0;
            bus.pack_do  <= 32'd0;
            bus.pack_be  <= 4'd0;
            bus.pack_vld <= 1'b0;
            word_cnt     <= 16'd0;
        end else if (clr) begin
            lane_idx     <= 2'd0;
            part         <= 24'd0;
            flush_pend   <= 1'b0;
            bus.pack_do  <= 32'd0;
            bus.pack_be  <= 4'd0;
            bus.pack_vld <= 1'b0;
            word_cnt     <= 16'd0;
        end else begin
            if (bus.pack_vld && bus.pack_rdy) begin
                bus.pack_vld <= 1'b0;
                word_cnt     <= word_cnt + 16'd1;
            end
            if (acc) begin
                if (lane_idx == 2'd3) begin
                    bus.pack_do  <= {b, part};
                    bus.pack_be  <= 4'b1111;
                    bus.pack_vld <= 1'b1;
                    lane_idx     <= 2'd0;
                    part         <= 24'd0;
                end else begin
                    case (lane_idx)
                        2'd0:    part[7:0]   <= b;
                        2'd1:    part[15:8]  <= b;
                        default: part[23:16] <= b;
                    endcase
                    lane_idx <= lane_idx + 2'd1;
                end
                // a flush alongside an accept is serviced after that sample lands
                if (flush) flush_pend <= 1'b1;
            end else if (flush_pend || flush) begin
                if (lane_idx == 2'd0) begin
                    flush_pend <= 1'b0;
                end else if (ofree) begin
                    bus.pack_do  <= {8'h00, part};
                    bus.pack_be  <= be_part;
                    bus.pack_vld <= 1'b1;
                    lane_idx     <= 2'd0;
                    part         <= 24'd0;
                    flush_pend   <= 1'b0;
                end else begin
                    flush_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_al_accel_outpack.sv
// tb/tb_al_accel_outpack.sv - self-checking bench for al_accel_outpack
module tb_al_accel_outpack;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clr;
    logic        flush;
    logic [31:0] out_offset;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic [15:0] word_cnt;

    al_accel_outpack_if bus();

    al_accel_outpack dut (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (clr),
        .bus        (bus.slave),
        .out_offset (out_offset),
        .act_min    (act_min),
        .act_max    (act_max),
        .flush      (flush),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          hs_count = 0;
    bit          rand_rdy = 1'b0;
    logic [7:0]  lane_q[$];
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] d);
        longint s;
        longint mn;
        longint mx;
        s  = longint'(signed'(d)) + longint'(signed'(out_offset));
        mn = longint'(signed'(act_min));
        mx = longint'(signed'(act_max));
        if (s < mn) s = mn;
        if (s > mx) s = mx;
        return s[7:0];
    endfunction

    function automatic void model_flush();
        logic [31:0] w;
        logic [3:0]  be;
        w  = 32'd0;
        be = 4'd0;
        if (lane_q.size() > 0) begin
            for (int i = 0; i < lane_q.size(); i++) begin
                w[8*i +: 8] = lane_q[i];
                be[i]       = 1'b1;
            end
            exp_q.push_back({be, w});
            lane_q.delete();
        end
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        lane_q.push_back(b);
        if (lane_q.size() == 4) model_flush();
    endfunction

    // word check at every handshake
    always @(negedge clk) begin
        if (resetn && !clr && bus.pack_vld && bus.pack_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word_vld", {31'd0, bus.pack_vld}, 32'd0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("word_data", bus.pack_do, e[31:0]);
                check("word_be", {28'd0, bus.pack_be}, {28'd0, e[35:32]});
            end
            hs_count++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.pack_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit fl);
        int         budget;
        bit         done;
        bit         took;
        logic [7:0] b;
        budget = 300;
        done   = 1'b0;
        took   = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_data = d;
        while (!done) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                b     = ref_byte(d);
                flush = fl;
                took  = 1'b1;
                done  = 1'b1;
            end else begin
                budget--;
                if (budget == 0) begin
                    check("in_rdy_timeout", {31'd0, bus.in_rdy}, 32'd1);
                    done = 1'b1;
                end
            end
            tick();
        end
        if (took) begin
            model_accept(b);
            if (fl) model_flush();
        end
        bus.in_vld = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while ((exp_q.size() != 0 || bus.pack_vld) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        resetn         = 1'b0;
        clr            = 1'b0;
        flush          = 1'b0;
        bus.in_vld     = 1'b0;
        bus.in_data    = 32'd0;
        bus.pack_rdy   = 1'b0;
        out_offset     = 32'd0;
        act_min        = 8'h80;
        act_max        = 8'h7F;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pack_vld", {31'd0, bus.pack_vld}, 32'd0);
        check("rst_pack_do", bus.pack_do, 32'd0);
        check("rst_pack_be", {28'd0, bus.pack_be}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        tick();

        // basic pack
        out_offset   = -32'sd128;
        bus.pack_rdy = 1'b1;
        send(32'd17, 1'b0);
        send(32'd200, 1'b0);
        send(-32'sd300, 1'b0);
        send(32'd0, 1'b0);
        @(negedge clk);
        check("basic_vld", {31'd0, bus.pack_vld}, 32'd1);
        check("basic_do", bus.pack_do, 32'h80804891);
        check("basic_be", {28'd0, bus.pack_be}, 32'hF);
        tick();
        @(negedge clk);
        check("basic_vld_drop", {31'd0, bus.pack_vld}, 32'd0);
        check("basic_word_cnt", {16'd0, word_cnt}, 32'd1);
        tick();

        // backpressure
        bus.pack_rdy = 1'b0;
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b0);
        send(32'd40, 1'b0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        bus.in_vld  = 1'b1;
        bus.in_data = 32'd4;
        @(negedge clk);
        check("bp_in_rdy_low", {31'd0, bus.in_rdy}, 32'd0);
        check("bp_hold_do", bus.pack_do, 32'hA89E948A);
        tick();
        @(negedge clk);
        check("bp_hold_vld", {31'd0, bus.pack_vld}, 32'd1);
        check("bp_hold_do2", bus.pack_do, 32'hA89E948A);
        tick();
        bus.pack_rdy = 1'b1;
        @(negedge clk);
        check("bp_in_rdy_high", {31'd0, bus.in_rdy}, 32'd1);
        model_accept(ref_byte(32'd4));
        tick();
        bus.in_vld = 1'b0;
        @(negedge clk);
        check("bp_no_bubble_vld", {31'd0, bus.pack_vld}, 32'd1);
        check("bp_second_do", bus.pack_do, 32'h84838281);
        tick();
        drain();

        // flush
        out_offset = 32'd0;
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        pulse_flush();
        @(negedge clk);
        check("flush_vld", {31'd0, bus.pack_vld}, 32'd1);
        check("flush_do", bus.pack_do, 32'h00000605);
        check("flush_be", {28'd0, bus.pack_be}, 32'h3);
        tick();
        pulse_flush();
        @(negedge clk);
        check("flush_empty_vld", {31'd0, bus.pack_vld}, 32'd0);
        tick();
        @(negedge clk);
        check("flush_empty_vld2", {31'd0, bus.pack_vld}, 32'd0);
        tick();
        send(32'd7, 1'b1);
        drain();

        // clamp and overflow
        act_min = 8'd0;
        act_max = 8'd100;
        send(-32'sd5, 1'b0);
        send(32'd1000, 1'b0);
        out_offset = 32'd1;
        send(32'h7FFFFFFF, 1'b0);
        act_min = 8'd10;
        act_max = 8'd5;
        send($urandom, 1'b0);
        @(negedge clk);
        check("clamp_do", bus.pack_do, 32'h05646400);
        tick();
        drain();
        act_min    = 8'h80;
        act_max    = 8'h7F;
        out_offset = 32'd0;

        // clear mid-word, with an accept dropped in the clear cycle
        send(32'd9, 1'b0);
        send(32'd9, 1'b0);
        clr         = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 32'd77;
        tick();
        clr        = 1'b0;
        bus.in_vld = 1'b0;
        lane_q.delete();
        exp_q.delete();
        hs_count = 0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        @(negedge clk);
        check("clr_do", bus.pack_do, 32'h04030201);
        check("clr_be", {28'd0, bus.pack_be}, 32'hF);
        tick();
        @(negedge clk);
        check("clr_word_cnt", {16'd0, word_cnt}, 32'd1);
        tick();

        // asynchronous reset mid-word
        send(32'd9, 1'b0);
        send(32'd9, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("arst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("arst_pack_be", {28'd0, bus.pack_be}, 32'd0);
        #1 resetn = 1'b1;
        lane_q.delete();
        exp_q.delete();
        hs_count = 0;
        tick();
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        @(negedge clk);
        check("arst_do", bus.pack_do, 32'h04030201);
        check("arst_be", {28'd0, bus.pack_be}, 32'hF);
        tick();
        @(negedge clk);
        check("arst_word_cnt_after", {16'd0, word_cnt}, 32'd1);
        tick();

        // randomized traffic with backpressure and flushes
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            if ($urandom_range(0, 19) == 0) begin
                out_offset = 32'($urandom_range(0, 400)) - 32'd200;
                act_min    = 8'($urandom_range(0, 255));
                act_max    = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'h7F;
            end
            d = ($urandom_range(0, 2) == 0) ? $urandom
                                            : 32'($urandom_range(0, 600)) - 32'd300;
            send(d, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) pulse_flush();
        end
        rand_rdy = 1'b0;
        tick();
        bus.pack_rdy = 1'b1;
        pulse_flush();
        drain();
        tick();
        @(negedge clk);
        check("rand_word_cnt", {16'd0, word_cnt}, 32'(hs_count[15:0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
